line_rasterizer: RTL and testbench

LINE_RASTERIZER -- requirements
Module: line_rasterizer

---
 rtl/line_raster_pkg.sv | 22 ++
 rtl/line_raster_step.sv | 45 ++++
 rtl/line_rasterizer.sv | 151 +++++++++++++++
 tb/tb_line_rasterizer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/line_raster_pkg.sv
// Shared constants for the Bresenham line rasterizer: FSM state encoding,
// error-term width helper and default framebuffer size.
package line_raster_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_STEP  = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  localparam int DEF_COORD_W = 8;
  localparam int DEF_FB_W    = 64;
  localparam int DEF_FB_H    = 64;
  localparam int ERR_W       = DEF_COORD_W + 2;

  // Two guard bits keep 2*err and err+dx+dy in range for any endpoints.
  function automatic int err_width(input int coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/line_raster_step.sv
// Combinational Bresenham step: next x, y and error term from the current
// position and the line's signed deltas and step directions.
module line_raster_step
  import line_raster_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int EW      = err_width(COORD_W)
) (
  input  logic [COORD_W-1:0]   cur_x_i,
  input  logic [COORD_W-1:0]   cur_y_i,
  input  logic signed [EW-1:0] err_i,
  input  logic signed [EW-1:0] dx_i,
  input  logic signed [EW-1:0] dy_i,
  input  logic                 sx_neg_i,
  input  logic                 sy_neg_i,
  output logic [COORD_W-1:0]   nxt_x_o,
  output logic [COORD_W-1:0]   nxt_y_o,
  output logic signed [EW-1:0] nxt_err_o
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic signed [EW-1:0] e2_s;
  logic signed [EW-1:0] err_x_s;

  // Both axis decisions use e2 from the pre-step error term.
  always_comb begin
    e2_s = err_i <<< 1;
    if (e2_s >= dy_i) begin
      err_x_s = err_i + dy_i;
      nxt_x_o = sx_neg_i ? (cur_x_i - ONE) : (cur_x_i + ONE);
    end else begin
      err_x_s = err_i;
      nxt_x_o = cur_x_i;
    end
    if (e2_s <= dx_i) begin
      nxt_err_o = err_x_s + dx_i;
      nxt_y_o   = sy_neg_i ? (cur_y_i - ONE) : (cur_y_i + ONE);
    end else begin
      nxt_err_o = err_x_s;
      nxt_y_o   = cur_y_i;
    end
  end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer with valid/ready pixel output.
// Define LINE_RASTER_CLIP_EN to skip pixels outside FB_W x FB_H.
module line_rasterizer
  import line_raster_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int FB_W    = DEF_FB_W,
  parameter int FB_H    = DEF_FB_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               done
);

  localparam int EW = err_width(COORD_W);
`ifdef LINE_RASTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  localparam logic [COORD_W:0] FB_W_L = (COORD_W+1)'(FB_W);
  localparam logic [COORD_W:0] FB_H_L = (COORD_W+1)'(FB_H);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic [COORD_W-1:0]   step_x_s, step_y_s, adx_s, ady_s;
  logic signed [EW-1:0] step_err_s;
  logic                 at_end_s, outside_s, in_step_s, advance_s;

  line_raster_step #(.COORD_W(COORD_W), .EW(EW)) u_step (
    .cur_x_i  (x_q),
    .cur_y_i  (y_q),
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .nxt_x_o  (step_x_s),
    .nxt_y_o  (step_y_s),
    .nxt_err_o(step_err_s)
  );

  // Clipped pixels are never presented, so they advance without waiting on ready.
  assign at_end_s  = (x_q == x1_q) && (y_q == y1_q);
  assign outside_s = CLIP_EN && (({1'b0, x_q} >= FB_W_L) || ({1'b0, y_q} >= FB_H_L));
  assign in_step_s = (state_q == ST_STEP);
  assign advance_s = in_step_s && (outside_s || pix_ready);
  assign adx_s     = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
  assign ady_s     = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);

  assign busy      = (state_q != ST_IDLE);
  assign pix_valid = in_step_s && !outside_s;
  assign pix_last  = pix_valid && at_end_s;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign done      = (state_q == ST_FIN);

  // Next-state and datapath update for the draw FSM.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x0;
          y_d     = y0;
          x1_d    = x1;
          y1_d    = y1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        dx_d     = $signed({2'b00, adx_s});
        dy_d     = -$signed({2'b00, ady_s});
        err_d    = $signed({2'b00, adx_s}) - $signed({2'b00, ady_s});
        sx_neg_d = (x1_q < x_q);
        sy_neg_d = (y1_q < y_q);
        state_d  = ST_STEP;
      end
      ST_STEP: begin
        if (advance_s && at_end_s) begin
          state_d = ST_FIN;
        end else if (advance_s) begin
          x_d   = step_x_s;
          y_d   = step_y_s;
          err_d = step_err_s;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed self-checking bench for line_rasterizer with hand-computed pixel lists.
module tb_line_rasterizer;

  logic       clk = 1'b0;
  logic       rst, start, pix_ready;
  logic [7:0] x0, y0, x1, y1;
  logic       busy, pix_valid, pix_last, done;
  logic [7:0] pix_x, pix_y;

  int tests = 0;
  int fails = 0;
  int ex[$];
  int ey[$];

  always #5 clk = ~clk;

  line_rasterizer dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1);
    @(negedge clk);
    x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("setup_no_valid", {31'd0, pix_valid}, 0);
    chk("setup_busy", {31'd0, busy}, 1);
  endtask

  // Accepts n pixels against ex/ey, checks stall stability, then the done pulse.
  task automatic collect(input int n, input bit toggle, input bit last_on_end, input int done_wait);
    int cnt = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [7:0] hx, hy;
    logic hl;
    pix_ready = 1'b1;
    while (cnt < n && guard < 200) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (toggle) pix_ready = ~pix_ready;
      if (stalled) begin
        chk("stall_x", {24'd0, pix_x}, {24'd0, hx});
        chk("stall_y", {24'd0, pix_y}, {24'd0, hy});
        chk("stall_last", {31'd0, pix_last}, {31'd0, hl});
        chk("stall_valid", {31'd0, pix_valid}, 1);
      end
      stalled = 1'b0;
      if (pix_valid && pix_ready) begin
        chk($sformatf("pix%0d_x", cnt), {24'd0, pix_x}, ex[cnt]);
        chk($sformatf("pix%0d_y", cnt), {24'd0, pix_y}, ey[cnt]);
        chk($sformatf("pix%0d_last", cnt), {31'd0, pix_last},
            (last_on_end && cnt == n - 1) ? 1 : 0);
        cnt++;
      end else if (pix_valid) begin
        stalled = 1'b1;
        hx = pix_x; hy = pix_y; hl = pix_last;
      end
    end
    chk("pixel_count", cnt, n);
    pix_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 50);
    chk("done_wait", guard, done_wait);
    chk("done_pulse", {31'd0, done}, 1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("idle_after_fin", {31'd0, busy}, 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, pix_valid}, 0);
    chk("rst_last", {31'd0, pix_last}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pix_x", {24'd0, pix_x}, 0);
    chk("rst_pix_y", {24'd0, pix_y}, 0);
    rst = 1'b0;

    // Shallow octant (0,0)->(5,2).
    ex = {0, 1, 2, 3, 4, 5}; ey = {0, 0, 1, 1, 2, 2};
    start_line(0, 0, 5, 2);
    collect(6, 1'b0, 1'b1, 1);

    // Degenerate single point, started right after the previous line.
    ex = {7}; ey = {7};
    start_line(7, 7, 7, 7);
    collect(1, 1'b0, 1'b1, 1);

    // Anti-diagonal with ready toggling every cycle.
    ex = {10, 9, 8, 7, 6, 5, 4, 3}; ey = {3, 4, 5, 6, 7, 8, 9, 10};
    start_line(10, 3, 3, 10);
    collect(8, 1'b1, 1'b1, 1);

    // Steep octant, negative x direction.
    ex = {2, 2, 1, 1, 0, 0}; ey = {1, 2, 3, 4, 5, 6};
    start_line(2, 1, 0, 6);
    collect(6, 1'b0, 1'b1, 1);

    // Vertical, negative y direction.
    ex = {4, 4, 4, 4}; ey = {9, 8, 7, 6};
    start_line(4, 9, 4, 6);
    collect(4, 1'b1, 1'b1, 1);

    // A start while busy, with changed inputs, must not disturb the current line.
    ex = {0, 1, 2, 3}; ey = {0, 0, 0, 0};
    start_line(0, 0, 3, 0);
    x0 = 8'd9; y0 = 8'd9; x1 = 8'd1; y1 = 8'd1; start = 1'b1;
    collect(4, 1'b0, 1'b1, 1);
    @(negedge clk);
    chk("dropped_start_idle", {31'd0, busy}, 0);

    // Line crossing the right framebuffer edge.
`ifdef LINE_RASTER_CLIP_EN
    ex = {60, 61, 62, 63}; ey = {0, 0, 0, 0};
    start_line(60, 0, 70, 0);
    collect(4, 1'b0, 1'b0, 8);
`else
    ex = {60, 61, 62, 63, 64, 65, 66, 67, 68, 69, 70};
    ey = {0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    start_line(60, 0, 70, 0);
    collect(11, 1'b0, 1'b1, 1);
`endif

    // Reset after three accepted pixels aborts the line.
    start_line(0, 0, 20, 0);
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_x", {24'd0, pix_x}, 3);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valid", {31'd0, pix_valid}, 0);
    chk("abort_last", {31'd0, pix_last}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_pix_x", {24'd0, pix_x}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || pix_valid || busy) seen = 1'b1;
    end
    chk("abort_no_activity", {31'd0, seen}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
